// File: rtl/aes_uart_frame_ctrl.sv
// Frame controller: UART rx bytes -> 128-bit key + plaintext -> AES core -> ciphertext bytes to UART tx.
// Optional inter-byte frame timeout is compiled in with `define FRAME_TIMEOUT_EN.
module aes_uart_frame_ctrl #(
   parameter int unsigned TIMEOUT_CLKS = 1041600
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic [127:0] key,
   output logic [127:0] block_in,
   output logic         aes_start,
   input  logic         aes_done,
   input  logic [127:0] aes_out,
   output logic [7:0]   tx_data,
   output logic         tx_start,
   input  logic         tx_busy,
   output logic         busy,
   output logic         overrun,
   output logic         frame_err
);

   localparam logic [2:0] StRxKey   = 3'd0;
   localparam logic [2:0] StRxPt    = 3'd1;
   localparam logic [2:0] StStart   = 3'd2;
   localparam logic [2:0] StWaitAes = 3'd3;
   localparam logic [2:0] StTxLoad  = 3'd4;
   localparam logic [2:0] StTxHold  = 3'd5;
   localparam logic [2:0] StTxWait  = 3'd6;

   logic [2:0]   r_state;
   logic [4:0]   r_byte_cnt;
   logic [3:0]   r_tx_cnt;
   logic [127:0] r_key;
   logic [127:0] r_block;
   logic [127:0] r_ct;
   logic [7:0]   r_tx_data;
   logic         r_aes_start;
   logic         r_overrun;
   logic         w_rx_state;
   logic         w_expire;

   assign w_rx_state = (r_state == StRxKey) || (r_state == StRxPt);

`ifdef FRAME_TIMEOUT_EN
   logic [20:0] r_idle;
   logic        r_frame_err;

   // A byte arriving on the expiry cycle wins over the timeout.
   assign w_expire = w_rx_state && (r_byte_cnt != 5'd0) && !rx_valid &&
                     (r_idle == 21'(TIMEOUT_CLKS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle      <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_expire;
         if (!w_rx_state || (r_byte_cnt == 5'd0) || rx_valid || w_expire) begin
            r_idle <= '0;
         end else begin
            r_idle <= r_idle + 21'd1;
         end
      end
   end

   assign frame_err = r_frame_err;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = TIMEOUT_CLKS[0];
   assign w_expire         = 1'b0;
   assign frame_err        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StRxKey;
         r_byte_cnt  <= '0;
         r_tx_cnt    <= '0;
         r_key       <= '0;
         r_block     <= '0;
         r_ct        <= '0;
         r_tx_data   <= '0;
         r_aes_start <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_aes_start <= 1'b0;
         r_overrun   <= rx_valid && !w_rx_state;
         case (r_state)
            StRxKey: begin
               if (rx_valid) begin
                  r_key      <= {r_key[119:0], rx_data};
                  r_byte_cnt <= r_byte_cnt + 5'd1;
                  if (r_byte_cnt == 5'd15) r_state <= StRxPt;
               end else if (w_expire) begin
                  r_byte_cnt <= '0;
               end
            end
            StRxPt: begin
               if (rx_valid) begin
                  r_block <= {r_block[119:0], rx_data};
                  if (r_byte_cnt == 5'd31) begin
                     r_byte_cnt <= '0;
                     r_state    <= StStart;
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 5'd1;
                  end
               end else if (w_expire) begin
                  r_byte_cnt <= '0;
                  r_state    <= StRxKey;
               end
            end
            StStart: begin
               r_aes_start <= 1'b1;
               r_state     <= StWaitAes;
            end
            StWaitAes: begin
               if (aes_done) begin
                  r_ct      <= aes_out;
                  r_tx_data <= aes_out[127:120];
                  r_tx_cnt  <= '0;
                  r_state   <= StTxLoad;
               end
            end
            StTxLoad: begin
               if (!tx_busy) begin
                  r_ct    <= {r_ct[119:0], 8'h00};
                  r_state <= StTxHold;
               end
            end
            // tx_busy only rises the cycle after tx_start, so it is not trusted here.
            StTxHold: r_state <= StTxWait;
            StTxWait: begin
               if (!tx_busy) begin
                  if (r_tx_cnt == 4'd15) begin
                     r_byte_cnt <= '0;
                     r_state    <= StRxKey;
                  end else begin
                     r_tx_cnt  <= r_tx_cnt + 4'd1;
                     r_tx_data <= r_ct[127:120];
                     r_state   <= StTxLoad;
                  end
               end
            end
            default: r_state <= StRxKey;
         endcase
      end
   end

   assign key       = r_key;
   assign block_in  = r_block;
   assign aes_start = r_aes_start;
   assign tx_data   = r_tx_data;
   assign tx_start  = (r_state == StTxLoad) && !tx_busy;
   assign busy      = !((r_state == StRxKey) && (r_byte_cnt == 5'd0));
   assign overrun   = r_overrun;

endmodule
